uart_rx_os: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_os_if.sv | 36 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx_os.sv | 139 +++++++++++++
 tb/tb_uart_rx_os.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared receiver state encoding, default sizing and clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLING_DEF = 8;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    // Minimum width of 1 so that degenerate sizes still yield a legal vector.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_os_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os_if
//  Description : Received-byte valid/ready handshake plus line error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_os_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output out_data,
        output out_valid,
        output frame_err,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  frame_err,
        input  overrun,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a single asynchronous input.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os
//  Description : Oversampled 8N1 UART receiver with valid/ready byte output.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = OVERSAMPLING_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         rx,
    output logic         busy,
    uart_rx_os_if.master rx_if
);

    localparam int c_SCNT_W = clog2(OVERSAMPLING);
    localparam int c_BIDX_W = clog2(DATA_BITS + 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_HALF = c_SCNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_LAST = c_SCNT_W'(OVERSAMPLING - 1);
    localparam logic [c_BIDX_W-1:0] c_BIDX_LAST = c_BIDX_W'(DATA_BITS - 1);

    uart_state_t            r_state;
    logic [c_SCNT_W-1:0]    r_scnt;
    logic [c_BIDX_W-1:0]    r_bidx;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   r_out_data;
    logic                   r_out_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_rxs;
    logic                   w_accept;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (reset),
        .i_d (rx),
        .o_q (w_rxs)
    );

    assign w_accept = r_out_valid && rx_if.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_scnt      <= '0;
            r_bidx      <= '0;
            r_shreg     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            if (tick) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rxs) begin
                            r_state <= START;
                            r_scnt  <= '0;
                        end
                    end
                    START: begin
                        if (r_scnt == c_SCNT_HALF) begin
                            if (w_rxs) begin
                                r_state <= IDLE;
                            end else begin
                                r_state <= DATA;
                                r_scnt  <= '0;
                                r_bidx  <= '0;
                            end
                        end else begin
                            r_scnt <= r_scnt + c_SCNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (r_scnt == c_SCNT_LAST) begin
                            r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
                            r_bidx  <= r_bidx + c_BIDX_W'(1);
                            r_scnt  <= '0;
                            if (r_bidx == c_BIDX_LAST) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_scnt <= r_scnt + c_SCNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (r_scnt == c_SCNT_LAST) begin
                            r_scnt <= '0;
                            if (w_rxs) begin
                                // A same-cycle accept frees the slot, so the new byte wins.
                                if (!r_out_valid || w_accept) begin
                                    r_out_data  <= r_shreg;
                                    r_out_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                                r_state <= IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_scnt <= r_scnt + c_SCNT_W'(1);
                        end
                    end
                    BREAK: begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy            = (r_state != IDLE);
    assign rx_if.out_data  = r_out_data;
    assign rx_if.out_valid = r_out_valid;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_os
//  Description : Self-checking bench for uart_rx_os driving serial frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int OVS = 8;
    localparam int DB  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;
    logic rx    = 1'b1;
    logic busy;

    int checks = 0;
    int errors = 0;

    uart_rx_os_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_os #(
        .OVERSAMPLING (OVS),
        .DATA_BITS    (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .rx    (rx),
        .busy  (busy),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, updated just after the edge so it is stable at the next one.
    int tick_phase = 0;
    always @(posedge clk) begin
        #1;
        tick_phase = (tick_phase + 1) % 4;
        tick = (tick_phase == 0);
    end

    // Protocol monitor: a byte is delivered whenever out_valid is high and the slot was free or just accepted.
    logic [DB-1:0] rxq[$];
    int   n_ferr = 0;
    int   n_ovr  = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (rx_if.frame_err) n_ferr++;
            if (rx_if.overrun) n_ovr++;
            if (rx_if.out_valid && (!pv || pr)) rxq.push_back(rx_if.out_data);
            pv = rx_if.out_valid;
            pr = rx_if.out_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (tick !== 1'b1);
            #1;
        end
    endtask

    // Start bit plus data bits, each held OVS ticks; returns with the last data bit still driven.
    task automatic send_head(input logic [DB-1:0] d);
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(OVS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            wait_ticks(OVS);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit);
        send_head(d);
        rx = stop_bit;
        wait_ticks(OVS);
        rx = 1'b1;
        wait_ticks(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", rx_if.out_valid); end
        checks++; if (rx_if.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 00", rx_if.out_data); end
        checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", rx_if.frame_err); end
        checks++; if (rx_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", rx_if.overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_basic();
        int f0, o0;
        rx_if.out_ready = 1'b0;
        rxq.delete();
        f0 = n_ferr;
        o0 = n_ovr;
        send_head(8'hA5);
        rx = 1'b1;
        wait_ticks(4);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", rx_if.out_valid); end
        @(posedge clk);
        #1;
        checks++; if (rx_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got %b want 1", rx_if.out_valid); end
        checks++; if (rx_if.out_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rx_if.out_data); end
        wait_ticks(3);
        checks++; if (n_ferr != f0 || n_ovr != o0) begin errors++; $display("FAIL basic_flags: ferr=%0d ovr=%0d want %0d %0d", n_ferr, n_ovr, f0, o0); end
        rx_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept_clear: got %b want 0", rx_if.out_valid); end
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'hA5) begin errors++; $display("FAIL basic_delivered: count=%0d want 1 of a5", rxq.size()); end
    endtask

    task automatic test_glitch();
        int f0, o0;
        rx_if.out_ready = 1'b1;
        rxq.delete();
        f0 = n_ferr;
        o0 = n_ovr;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_in_start: busy got %b want 1", busy); end
        wait_ticks(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle: busy got %b want 0", busy); end
        wait_ticks(20);
        checks++; if (rxq.size() != 0 || n_ferr != f0 || n_ovr != o0) begin errors++; $display("FAIL glitch_no_output: bytes=%0d ferr=%0d ovr=%0d want 0 %0d %0d", rxq.size(), n_ferr, n_ovr, f0, o0); end
    endtask

    task automatic test_frame_err();
        int f0;
        rx_if.out_ready = 1'b1;
        rxq.delete();
        f0 = n_ferr;
        send_head(8'h3C);
        rx = 1'b0;
        wait_ticks(5);
        checks++; if (rx_if.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse: got %b want 1", rx_if.frame_err); end
        checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_valid: got %b want 0", rx_if.out_valid); end
        wait_ticks(40);
        rx = 1'b1;
        wait_ticks(8);
        checks++; if (n_ferr != f0 + 1) begin errors++; $display("FAIL ferr_break_single: got %0d pulses want 1", n_ferr - f0); end
        checks++; if (busy !== 1'b0 || rxq.size() != 0) begin errors++; $display("FAIL ferr_idle_after_break: busy=%b bytes=%0d want 0 0", busy, rxq.size()); end
        send_frame(8'h81, 1'b1);
        wait_ticks(2);
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h81) begin errors++; $display("FAIL ferr_recover: count=%0d want 1 of 81", rxq.size()); end
        checks++; if (n_ferr != f0 + 1) begin errors++; $display("FAIL ferr_recover_flags: got %0d pulses want 1", n_ferr - f0); end
    endtask

    task automatic test_overrun();
        int o0;
        rx_if.out_ready = 1'b0;
        rxq.delete();
        o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++; if (rx_if.out_valid !== 1'b1 || rx_if.out_data !== 8'h11) begin errors++; $display("FAIL ovr_keep_old: valid=%b data=%h want 1 11", rx_if.out_valid, rx_if.out_data); end
        checks++; if (n_ovr != o0 + 1) begin errors++; $display("FAIL ovr_pulse_count: got %0d want 1", n_ovr - o0); end
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h11) begin errors++; $display("FAIL ovr_delivered: count=%0d want 1 of 11", rxq.size()); end
        rx_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_clear: got %b want 0", rx_if.out_valid); end
    endtask

    task automatic test_back_to_back();
        int o0;
        rx_if.out_ready = 1'b0;
        rxq.delete();
        o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_head(8'h22);
        rx = 1'b1;
        wait_ticks(4);
        repeat (3) @(posedge clk);
        #1;
        rx_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_if.out_valid !== 1'b1 || rx_if.out_data !== 8'h22) begin errors++; $display("FAIL b2b_new_wins: valid=%b data=%h want 1 22", rx_if.out_valid, rx_if.out_data); end
        wait_ticks(3);
        checks++; if (n_ovr != o0) begin errors++; $display("FAIL b2b_no_overrun: got %0d pulses want 0", n_ovr - o0); end
        checks++; if (rxq.size() != 2 || rxq[0] !== 8'h11 || rxq[1] !== 8'h22) begin errors++; $display("FAIL b2b_delivered: count=%0d want 11 then 22", rxq.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int f0, o0;
        rx_if.out_ready = 1'b1;
        f0 = n_ferr;
        o0 = n_ovr;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(OVS * 3 + 4);
        reset = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || rx_if.out_valid !== 1'b0 || rx_if.frame_err !== 1'b0 || rx_if.overrun !== 1'b0) begin errors++; $display("FAIL midrst_outputs: busy=%b valid=%b ferr=%b ovr=%b want all 0", busy, rx_if.out_valid, rx_if.frame_err, rx_if.overrun); end
        checks++; if (rx_if.out_data !== '0) begin errors++; $display("FAIL midrst_data: got %h want 00", rx_if.out_data); end
        rxq.delete();
        wait_ticks(16);
        send_frame(8'h5A, 1'b1);
        wait_ticks(2);
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h5A) begin errors++; $display("FAIL midrst_only_new: count=%0d want 1 of 5a", rxq.size()); end
        checks++; if (n_ferr != f0 || n_ovr != o0) begin errors++; $display("FAIL midrst_flags: ferr=%0d ovr=%0d want %0d %0d", n_ferr, n_ovr, f0, o0); end
    endtask

    task automatic test_random();
        logic [DB-1:0] expq[$];
        logic [DB-1:0] b;
        int f0, o0;
        rx_if.out_ready = 1'b1;
        rxq.delete();
        f0 = n_ferr;
        o0 = n_ovr;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_ticks(1);
                rx = 1'b0;
                wait_ticks($urandom_range(1, 2));
                rx = 1'b1;
                wait_ticks(6);
            end
            b = DB'($urandom);
            expq.push_back(b);
            send_frame(b, 1'b1);
            wait_ticks($urandom_range(0, 12));
        end
        wait_ticks(2);
        checks++; if (rxq.size() != expq.size()) begin errors++; $display("FAIL rand_count: got %0d bytes want %0d", rxq.size(), expq.size()); end
        for (int k = 0; k < expq.size() && k < rxq.size(); k++) begin
            checks++; if (rxq[k] !== expq[k]) begin errors++; $display("FAIL rand_byte_%0d: got %h want %h", k, rxq[k], expq[k]); end
        end
        checks++; if (n_ferr != f0 || n_ovr != o0) begin errors++; $display("FAIL rand_flags: ferr=%0d ovr=%0d want %0d %0d", n_ferr, n_ovr, f0, o0); end
    endtask

    initial begin
        rx_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
